bus_ram: RTL and testbench
==========================

Name: bus_ram

Overview:
- Parametrised successor to the 16x8 bus memory of the 8-bit machine.
- Generalised data width and depth; optional auto-increment addressing.
- Adds a bulk programming port with a valid/ready handshake, so a testbench or loader can fill RAM through hardware instead of backdoor file loading.
- Sits on the shared machine bus; the bus mux selects bus_out when en_read_mem is high.

Parameters:
- DATA_WIDTH, 8: word width and bus width.
- ADDR_WIDTH, 4: address width; depth is 2**ADDR_WIDTH.
- AUTO_INC, 0: when 1, the address post-increments after every CPU write (en_write_mem).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- bus_in  input  DATA_WIDTH  machine bus value.
- bus_out  output  DATA_WIDTH  read data; zero when not reading.
- en_write_mem_adr  input  1  load address register from bus_in[ADDR_WIDTH-1:0].
- en_write_mem  input  1  write bus_in to data[adr].
- en_read_mem  input  1  drive data[adr] onto bus_out.
- en_inc_adr  input  1  increment address register.
- adr  output  ADDR_WIDTH  current address register.
- prog_start  input  1  begin bulk load at address 0.
- prog_valid  input  1  prog_data holds a word.
- prog_data  input  DATA_WIDTH  word to load.
- prog_last  input  1  qualifies prog_valid: this word ends the load.
- prog_ready  output  1  loader may transfer.
- prog_busy  output  1  load in progress.
- prog_done  output  1  one-cycle pulse when the load finishes.

Behaviour:
- Reset (reset low, asynchronous):
  - adr=0, state=IDLE.
  - prog_ready=0, prog_busy=0, prog_done=0.
  - Memory contents are NOT cleared.
- bus_out is combinational: en_read_mem && state==IDLE ? data[adr] : 0. It follows adr changes in the same cycle.
- IDLE priority per edge:
  1. prog_start: adr<=0, go to LOAD. All CPU controls are ignored that cycle.
  2. en_write_mem_adr: adr<=bus_in[ADDR_WIDTH-1:0]; upper bits are ignored.
  3. en_write_mem: data[adr]<=bus_in. adr increments if AUTO_INC=1 or en_inc_adr=1; never by 2.
  4. en_inc_adr alone: adr<=adr+1.
- Address arithmetic: modulo 2**ADDR_WIDTH; max wraps to 0 silently.
- Simultaneous en_write_mem_adr and en_write_mem: the address load wins and no write occurs.
- en_read_mem concurrent with a write: bus_out shows the old word in that cycle and the new word after the edge.
- LOAD state:
  - prog_ready=1, prog_busy=1.
  - CPU controls are ignored and bus_out=0.
  - Transfer occurs when prog_valid && prog_ready: data[adr]<=prog_data, adr<=adr+1.
  - Transfer with prog_last=1, or transfer at adr==2**ADDR_WIDTH-1 → DONE. adr still advances (wraps to 0 on the full-depth case).
  - prog_start while in LOAD is ignored.
- DONE state (one cycle):
  - prog_done=1, prog_busy=1, prog_ready=0.
  - Then → IDLE with adr left at last written address + 1.
- Reset mid-LOAD: returns to IDLE, adr=0, no prog_done. Words already written are retained.
- prog_valid without prog_ready (IDLE/DONE): no effect; the loader must hold the word.

Test Plan:
- Default params: write 0x2A at adr 5 (en_write_mem_adr with bus 0x05, then en_write_mem with bus 0x2A), then read → bus_out=0x2A; with en_read_mem=0, bus_out=0.
- Address load with bus_in=0xF3 and ADDR_WIDTH=4 → adr=3. At adr=15, en_inc_adr → adr=0.
- AUTO_INC=1: set adr=14, write 0x11, 0x22, 0x33 on consecutive cycles → data[14]=0x11, data[15]=0x22, data[0]=0x33, final adr=1. Write plus en_inc_adr in one cycle → single increment.
- Bulk load: prog_start, then 3 words 0xA0,0xA1,0xA2 with a one-cycle valid gap and prog_last on 0xA2:
  - data[0..2] loaded.
  - prog_done pulses exactly once, one cycle after the last transfer.
  - adr=3 after return to IDLE.
  - en_write_mem asserted during LOAD has no effect.
- Full-depth load with ADDR_WIDTH=3, 8 words, no prog_last → DONE after the 8th transfer, adr=0.
- Reset asserted mid-load after 2 words → immediately IDLE, prog_busy=0, no prog_done, data[0..1] kept, adr=0.

Source files
------------

// File: rtl/bus_ram.sv
// Word-addressed bus memory for the 8-bit machine with a CPU port and a
// valid/ready bulk programming port. Memory contents survive reset.
module bus_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter bit AUTO_INC   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  input  logic                  en_write_mem_adr,
  input  logic                  en_write_mem,
  input  logic                  en_read_mem,
  input  logic                  en_inc_adr,
  output logic [ADDR_WIDTH-1:0] adr,
  input  logic                  prog_start,
  input  logic                  prog_valid,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_last,
  output logic                  prog_ready,
  output logic                  prog_busy,
  output logic                  prog_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   adr_reg;
  logic [ADDR_WIDTH-1:0]   adr_next;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      adr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      adr_reg   <= adr_next;
    end
  end

  // The write always targets the current address; both ports share it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[adr_reg] <= mem_wdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    adr_next   = adr_reg;
    mem_we     = 1'b0;
    mem_wdata  = bus_in;
    case (state_reg)
      IDLE: begin
        if (prog_start) begin
          adr_next   = '0;
          state_next = LOAD;
        end else if (en_write_mem_adr) begin
          adr_next = bus_in[ADDR_WIDTH-1:0];
        end else if (en_write_mem) begin
          mem_we = 1'b1;
          if (AUTO_INC || en_inc_adr) begin
            adr_next = adr_reg + ADR_ONE;
          end
        end else if (en_inc_adr) begin
          adr_next = adr_reg + ADR_ONE;
        end
      end
      LOAD: begin
        // prog_ready is high throughout LOAD, so valid alone completes a transfer.
        if (prog_valid) begin
          mem_we    = 1'b1;
          mem_wdata = prog_data;
          adr_next  = adr_reg + ADR_ONE;
          if (prog_last || adr_reg == ADR_MAX) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign adr        = adr_reg;
  assign prog_ready = (state_reg == LOAD);
  assign prog_busy  = (state_reg == LOAD) || (state_reg == DONE);
  assign prog_done  = (state_reg == DONE);
  assign bus_out    = (en_read_mem && state_reg == IDLE) ? mem[adr_reg] : '0;

endmodule

// File: tb/tb_bus_ram.sv
// Directed bench for bus_ram: default, auto-increment and 3-bit-address
// instances, each checked against hand-computed values.
module tb_bus_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Instance A: default parameters
  logic       a_reset, a_wa, a_wm, a_rd, a_inc, a_start, a_valid, a_last;
  logic [7:0] a_bus_in, a_bus_out, a_pdata;
  logic [3:0] a_adr;
  logic       a_ready, a_busy, a_done;

  // Instance B: AUTO_INC=1
  logic       b_reset, b_wa, b_wm, b_rd, b_inc, b_start, b_valid, b_last;
  logic [7:0] b_bus_in, b_bus_out, b_pdata;
  logic [3:0] b_adr;
  logic       b_ready, b_busy, b_done;

  // Instance C: ADDR_WIDTH=3
  logic       c_reset, c_wa, c_wm, c_rd, c_inc, c_start, c_valid, c_last;
  logic [7:0] c_bus_in, c_bus_out, c_pdata;
  logic [2:0] c_adr;
  logic       c_ready, c_busy, c_done;

  bus_ram dut_a (
    .clk(clk), .reset(a_reset), .bus_in(a_bus_in), .bus_out(a_bus_out),
    .en_write_mem_adr(a_wa), .en_write_mem(a_wm), .en_read_mem(a_rd),
    .en_inc_adr(a_inc), .adr(a_adr), .prog_start(a_start), .prog_valid(a_valid),
    .prog_data(a_pdata), .prog_last(a_last), .prog_ready(a_ready),
    .prog_busy(a_busy), .prog_done(a_done)
  );

  bus_ram #(.AUTO_INC(1'b1)) dut_b (
    .clk(clk), .reset(b_reset), .bus_in(b_bus_in), .bus_out(b_bus_out),
    .en_write_mem_adr(b_wa), .en_write_mem(b_wm), .en_read_mem(b_rd),
    .en_inc_adr(b_inc), .adr(b_adr), .prog_start(b_start), .prog_valid(b_valid),
    .prog_data(b_pdata), .prog_last(b_last), .prog_ready(b_ready),
    .prog_busy(b_busy), .prog_done(b_done)
  );

  bus_ram #(.ADDR_WIDTH(3)) dut_c (
    .clk(clk), .reset(c_reset), .bus_in(c_bus_in), .bus_out(c_bus_out),
    .en_write_mem_adr(c_wa), .en_write_mem(c_wm), .en_read_mem(c_rd),
    .en_inc_adr(c_inc), .adr(c_adr), .prog_start(c_start), .prog_valid(c_valid),
    .prog_data(c_pdata), .prog_last(c_last), .prog_ready(c_ready),
    .prog_busy(c_busy), .prog_done(c_done)
  );

  int a_done_count = 0;
  always @(posedge clk) begin
    if (a_done) a_done_count <= a_done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
      $display("  ok   %-22s = 0x%0h", tag, observed);
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a_wa, a_wm, a_rd, a_inc, a_start, a_valid, a_last} = '0;
    {b_wa, b_wm, b_rd, b_inc, b_start, b_valid, b_last} = '0;
    {c_wa, c_wm, c_rd, c_inc, c_start, c_valid, c_last} = '0;
    a_bus_in = '0; a_pdata = '0;
    b_bus_in = '0; b_pdata = '0;
    c_bus_in = '0; c_pdata = '0;
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    tick(); tick();

    check("rst adr", a_adr, 0);
    check("rst ready", a_ready, 0);
    check("rst busy", a_busy, 0);
    check("rst done", a_done, 0);
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    tick();

    // Basic write/read at address 5
    a_wa = 1; a_bus_in = 8'h05; tick(); a_wa = 0;
    check("adr load 5", a_adr, 5);
    a_wm = 1; a_bus_in = 8'h2A; tick(); a_wm = 0;
    check("adr no autoinc", a_adr, 5);
    a_rd = 1; #1;
    check("read 0x2A", a_bus_out, 8'h2A);
    a_rd = 0; #1;
    check("bus_out idle", a_bus_out, 0);

    // Address load beats write in the same cycle
    a_wa = 1; a_wm = 1; a_bus_in = 8'h07; tick(); a_wa = 0; a_wm = 0;
    check("adr wins", a_adr, 7);
    a_wa = 1; a_bus_in = 8'h05; tick(); a_wa = 0;
    a_rd = 1; #1;
    check("no write on adr load", a_bus_out, 8'h2A);

    // Read concurrent with write: old word before the edge, new after
    a_wm = 1; a_bus_in = 8'h3C; #1;
    check("read old word", a_bus_out, 8'h2A);
    tick(); a_wm = 0;
    check("read new word", a_bus_out, 8'h3C);
    a_rd = 0;

    // Upper bus bits ignored; wrap 15 -> 0
    a_wa = 1; a_bus_in = 8'hF3; tick(); a_wa = 0;
    check("adr from 0xF3", a_adr, 3);
    a_wa = 1; a_bus_in = 8'h0F; tick(); a_wa = 0;
    a_inc = 1; tick(); a_inc = 0;
    check("inc wrap", a_adr, 0);

    // Bulk load with a valid gap; en_write_mem held to prove it is ignored
    a_wa = 1; a_bus_in = 8'h09; tick(); a_wa = 0;
    a_start = 1; tick(); a_start = 0;
    check("load adr 0", a_adr, 0);
    check("load ready", a_ready, 1);
    check("load busy", a_busy, 1);
    a_wm = 1; a_bus_in = 8'hEE; a_rd = 1; #1;
    check("load bus_out 0", a_bus_out, 0);
    a_valid = 1; a_pdata = 8'hA0; tick();
    a_valid = 0; tick();
    check("gap adr", a_adr, 1);
    a_valid = 1; a_pdata = 8'hA1; tick();
    a_pdata = 8'hA2; a_last = 1; tick();
    a_valid = 0; a_last = 0; a_wm = 0; a_rd = 0;
    check("done pulse", a_done, 1);
    check("done busy", a_busy, 1);
    check("done ready", a_ready, 0);
    tick();
    check("done cleared", a_done, 0);
    check("idle busy", a_busy, 0);
    check("post-load adr", a_adr, 3);
    check("done count", a_done_count, 1);
    a_wa = 1; a_bus_in = 8'h00; tick(); a_wa = 0;
    a_rd = 1; #1;
    check("data[0]", a_bus_out, 8'hA0);
    a_inc = 1; tick(); a_inc = 0;
    check("data[1]", a_bus_out, 8'hA1);
    a_inc = 1; tick(); a_inc = 0;
    check("data[2]", a_bus_out, 8'hA2);
    a_rd = 0;

    // Reset in the middle of a load
    a_start = 1; tick(); a_start = 0;
    a_valid = 1; a_pdata = 8'h10; tick();
    a_pdata = 8'h11; tick();
    a_valid = 0;
    check("mid-load adr", a_adr, 2);
    a_reset = 0; #1;
    check("rst mid busy", a_busy, 0);
    check("rst mid ready", a_ready, 0);
    check("rst mid adr", a_adr, 0);
    tick();
    a_reset = 1; tick();
    check("rst mid done cnt", a_done_count, 1);
    a_rd = 1; #1;
    check("kept data[0]", a_bus_out, 8'h10);
    a_inc = 1; tick(); a_inc = 0;
    check("kept data[1]", a_bus_out, 8'h11);
    a_rd = 0;

    // AUTO_INC instance: three writes wrapping through 15 -> 0
    b_wa = 1; b_bus_in = 8'h0E; tick(); b_wa = 0;
    b_wm = 1;
    b_bus_in = 8'h11; tick();
    b_bus_in = 8'h22; tick();
    b_bus_in = 8'h33; tick();
    b_wm = 0;
    check("autoinc final adr", b_adr, 1);
    b_wa = 1; b_bus_in = 8'h0E; tick(); b_wa = 0;
    b_rd = 1; #1;
    check("auto data[14]", b_bus_out, 8'h11);
    b_inc = 1; tick(); b_inc = 0;
    check("auto data[15]", b_bus_out, 8'h22);
    b_inc = 1; tick(); b_inc = 0;
    check("auto data[0]", b_bus_out, 8'h33);
    b_rd = 0;
    b_wa = 1; b_bus_in = 8'h04; tick(); b_wa = 0;
    b_wm = 1; b_inc = 1; b_bus_in = 8'h44; tick(); b_wm = 0; b_inc = 0;
    check("write+inc single", b_adr, 5);

    // Full-depth load on the 8-word instance, no prog_last
    c_start = 1; tick(); c_start = 0;
    c_valid = 1;
    for (int i = 0; i < 7; i++) begin
      c_pdata = 8'hC0 + 8'(i); tick();
    end
    check("c 7th busy", c_busy, 1);
    check("c 7th no done", c_done, 0);
    c_pdata = 8'hC7; tick();
    c_valid = 0;
    check("c full done", c_done, 1);
    check("c full adr", c_adr, 0);
    tick();
    check("c idle busy", c_busy, 0);
    check("c idle adr", c_adr, 0);
    c_rd = 1; #1;
    check("c data[0]", c_bus_out, 8'hC0);
    for (int i = 1; i < 8; i++) begin
      c_inc = 1; tick(); c_inc = 0; #1;
      check($sformatf("c data[%0d]", i), c_bus_out, 8'hC0 + 8'(i));
    end
    c_rd = 0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
